// File: rtl/decoder_pkg.sv
// Shared types and helpers for the sequenced decoder and related strobe
// generators: controller state encoding, mode constants and a one-hot
// helper that is sized for the widest supported output bank.
package decoder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    SCAN = 2'd2
  } dec_state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Widest output bank the helper supports (SEL_W up to 8).
  localparam int MAX_OUT = 256;

  // One-hot vector with bit idx set, or all-zero when idx is outside the bank.
  function automatic logic [MAX_OUT-1:0] onehot(input int unsigned idx,
                                                input int unsigned num_out);
    logic [MAX_OUT-1:0] one;
    one = {{(MAX_OUT-1){1'b0}}, 1'b1};
    if (idx < num_out) begin
      return one << idx;
    end
    return '0;
  endfunction

endpackage

// File: rtl/decoder_seq_dwell_counter.sv
// Loadable down-counter that measures how long a strobe line stays asserted.
// load takes priority over counting; counting stops at zero; done flags zero.
module dwell_counter #(
  parameter int CNT_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             done
);

  // Count register: synchronous clear, load, or saturating decrement.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments in clocked blocks so every register
    // samples pre-edge values, independent of block ordering.
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/decoder_seq.sv
// Registered, parametrised select decoder for peripheral strobe banks.
// Direct mode: a valid/ready handshake picks one line, held for DWELL cycles.
// Scan mode: lines are walked round-robin, DWELL cycles each.
// Optional build macro DECODER_SEQ_ERR_EN adds a sticky err output that
// records any accepted out-of-range select.
module decoder_seq
  import decoder_pkg::*;
#(
  parameter int SEL_W   = 3,
  parameter int NUM_OUT = 8,
  parameter int DWELL   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               mode,
  input  logic               sel_valid,
  input  logic [SEL_W-1:0]   sel,
  output logic               sel_ready,
  output logic [NUM_OUT-1:0] y,
  output logic               y_valid,
  output logic [SEL_W-1:0]   idx
`ifdef DECODER_SEQ_ERR_EN
  ,
  output logic               err
`endif
);

  localparam int CNT_W = ($clog2(DWELL + 1) < 1) ? 1 : $clog2(DWELL + 1);
  localparam logic [CNT_W-1:0] DWELL_M1 = CNT_W'(DWELL - 1);
  // Highest legal index; comparing against it keeps the check within SEL_W
  // bits even when NUM_OUT == 2**SEL_W.
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_OUT - 1);

  dec_state_t         state, state_d;
  logic [NUM_OUT-1:0] y_d;
  logic [SEL_W-1:0]   idx_d;
  logic               accept;
  logic               in_range;
  logic               cnt_load;
  logic [CNT_W-1:0]   cnt_load_val;
  logic               cnt_dec;
  logic [CNT_W-1:0]   dwell_cnt;
  logic               dwell_done;

  assign sel_ready = (state == IDLE) && en && (mode == MODE_DIRECT) && !rst;
  assign accept    = sel_valid && sel_ready;
  assign in_range  = (sel <= LAST_IDX);
  assign y_valid   = |y;

  dwell_counter #(
    .CNT_W (CNT_W)
  ) u_dwell (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .en       (cnt_dec),
    .cnt      (dwell_cnt),
    .done     (dwell_done)
  );

  // State, output line and index registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      y     <= '0;
      idx   <= '0;
    end else begin
      state <= state_d;
      y     <= y_d;
      idx   <= idx_d;
    end
  end

  // Next-state, next index and dwell-counter control; y follows idx outside IDLE.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path
    // leaves one unassigned and no latch is inferred.
    state_d      = state;
    idx_d        = idx;
    cnt_load     = 1'b0;
    cnt_load_val = DWELL_M1;
    cnt_dec      = 1'b0;

    if (!en) begin
      // Disable wins over any dwell in progress; also clear a partial count.
      state_d      = IDLE;
      idx_d        = '0;
      cnt_load     = (dwell_cnt != '0);
      cnt_load_val = '0;
    end else begin
      case (state)
        IDLE: begin
          idx_d = '0;
          if (mode == MODE_SCAN) begin
            state_d  = SCAN;
            cnt_load = 1'b1;
          end else if (accept && in_range) begin
            state_d  = HOLD;
            idx_d    = sel;
            cnt_load = 1'b1;
          end
          // Out-of-range handshakes are consumed and dropped here.
        end
        HOLD: begin
          if (dwell_done) begin
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            cnt_dec = 1'b1;
          end
        end
        SCAN: begin
          if (!dwell_done) begin
            cnt_dec = 1'b1;
          end else if (mode == MODE_SCAN) begin
            idx_d    = (idx == LAST_IDX) ? '0 : idx + SEL_W'(1);
            cnt_load = 1'b1;
          end else begin
            state_d = IDLE;
            idx_d   = '0;
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = '0;
        end
      endcase
    end

    y_d = '0;
    if (state_d != IDLE) begin
      y_d = NUM_OUT'(onehot(32'(idx_d), NUM_OUT));
    end
  end

`ifdef DECODER_SEQ_ERR_EN
  // Sticky flag for dropped out-of-range requests; only rst clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (accept && !in_range) begin
      err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_decoder_seq.sv
// Scoreboard bench for decoder_seq: two instances (8 lines / dwell 4 and
// 6 lines / dwell 2). Stimulus pushes one expected {y, idx} entry per cycle
// the line should be asserted; monitors pop on every asserted cycle.
module tb_decoder_seq;

  typedef struct {
    logic [7:0] y;
    logic [2:0] idx;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  exp_t q_a[$];
  exp_t q_b[$];

  // Instance A: default geometry.
  logic       rst_a = 1'b1, en_a = 1'b0, mode_a = 1'b0, sel_valid_a = 1'b0;
  logic [2:0] sel_a = '0;
  logic       sel_ready_a, y_valid_a;
  logic [7:0] y_a;
  logic [2:0] idx_a;

  // Instance B: six lines, dwell 2.
  logic       rst_b = 1'b1, en_b = 1'b0, mode_b = 1'b0, sel_valid_b = 1'b0;
  logic [2:0] sel_b = '0;
  logic       sel_ready_b, y_valid_b;
  logic [5:0] y_b;
  logic [2:0] idx_b;

`ifdef DECODER_SEQ_ERR_EN
  logic err_a, err_b;
`endif

  decoder_seq #(.SEL_W(3), .NUM_OUT(8), .DWELL(4)) dut_a (
    .clk       (clk),
    .rst       (rst_a),
    .en        (en_a),
    .mode      (mode_a),
    .sel_valid (sel_valid_a),
    .sel       (sel_a),
    .sel_ready (sel_ready_a),
    .y         (y_a),
    .y_valid   (y_valid_a),
    .idx       (idx_a)
`ifdef DECODER_SEQ_ERR_EN
    ,
    .err       (err_a)
`endif
  );

  decoder_seq #(.SEL_W(3), .NUM_OUT(6), .DWELL(2)) dut_b (
    .clk       (clk),
    .rst       (rst_b),
    .en        (en_b),
    .mode      (mode_b),
    .sel_valid (sel_valid_b),
    .sel       (sel_b),
    .sel_ready (sel_ready_b),
    .y         (y_b),
    .y_valid   (y_valid_b),
    .idx       (idx_b)
`ifdef DECODER_SEQ_ERR_EN
    ,
    .err       (err_b)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_a(input logic [7:0] y, input logic [2:0] idx, input int n);
    exp_t e;
    e.y = y;
    e.idx = idx;
    for (int i = 0; i < n; i++) q_a.push_back(e);
  endtask

  task automatic push_b(input logic [7:0] y, input logic [2:0] idx, input int n);
    exp_t e;
    e.y = y;
    e.idx = idx;
    for (int i = 0; i < n; i++) q_b.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor A: pop one expectation per asserted cycle.
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (!$isunknown(y_a)) begin
      check("a_y_valid_vs_y", {31'b0, y_valid_a}, {31'b0, |y_a});
      if (y_a != '0) begin
        if (q_a.size() == 0) begin
          check("a_unexpected_y", {24'b0, y_a}, 32'h0);
        end else begin
          e = q_a.pop_front();
          check("a_y", {24'b0, y_a}, {24'b0, e.y});
          check("a_idx", {29'b0, idx_a}, {29'b0, e.idx});
        end
      end else begin
        check("a_idx_zero_when_idle", {29'b0, idx_a}, 32'h0);
      end
    end
  end

  // Monitor B: same scheme for the six-line instance.
  always @(negedge clk) begin : mon_b
    exp_t e;
    if (!$isunknown(y_b)) begin
      check("b_y_valid_vs_y", {31'b0, y_valid_b}, {31'b0, |y_b});
      if (y_b != '0) begin
        if (q_b.size() == 0) begin
          check("b_unexpected_y", {26'b0, y_b}, 32'h0);
        end else begin
          e = q_b.pop_front();
          check("b_y", {26'b0, y_b}, {24'b0, e.y});
          check("b_idx", {29'b0, idx_b}, {29'b0, e.idx});
        end
      end else begin
        check("b_idx_zero_when_idle", {29'b0, idx_b}, 32'h0);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  initial begin : stim
    tick();
    tick();

    // Reset state of both instances.
    check("a_reset_y", {24'b0, y_a}, 32'h0);
    check("a_reset_idx", {29'b0, idx_a}, 32'h0);
    check("a_reset_y_valid", {31'b0, y_valid_a}, 32'h0);
    check("a_reset_ready", {31'b0, sel_ready_a}, 32'h0);
    check("b_reset_y", {26'b0, y_b}, 32'h0);
    check("b_reset_ready", {31'b0, sel_ready_b}, 32'h0);

    // Direct decode, sel = 5: 0x20 for exactly four cycles, stalled meanwhile.
    rst_a = 1'b0;
    en_a  = 1'b1;
    mode_a = 1'b0;
    #1;
    check("t1_ready_idle", {31'b0, sel_ready_a}, 32'h1);
    sel_a = 3'd5;
    sel_valid_a = 1'b1;
    push_a(8'h20, 3'd5, 4);
    tick();
    sel_valid_a = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("t1_ready_hold", {31'b0, sel_ready_a}, 32'h0);
      tick();
    end
    check("t1_y_off", {24'b0, y_a}, 32'h0);
    check("t1_ready_back", {31'b0, sel_ready_a}, 32'h1);

    // Back-to-back: sel 2 then 6 with valid held; one idle cycle between.
    sel_a = 3'd2;
    sel_valid_a = 1'b1;
    push_a(8'h04, 3'd2, 4);
    push_a(8'h40, 3'd6, 4);
    tick();
    sel_a = 3'd6;
    for (int k = 0; k < 4; k++) begin
      check("t2_ready_hold", {31'b0, sel_ready_a}, 32'h0);
      tick();
    end
    check("t2_gap_y", {24'b0, y_a}, 32'h0);
    check("t2_gap_ready", {31'b0, sel_ready_a}, 32'h1);
    tick();
    sel_valid_a = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    check("t2_y_off", {24'b0, y_a}, 32'h0);

    // Reset mid-hold: sel 1 asserted two cycles, rst during the second.
    sel_a = 3'd1;
    sel_valid_a = 1'b1;
    push_a(8'h02, 3'd1, 2);
    tick();
    sel_valid_a = 1'b0;
    tick();
    rst_a = 1'b1;
    #1;
    check("t6_ready_in_reset", {31'b0, sel_ready_a}, 32'h0);
    tick();
    check("t6_y_after_rst", {24'b0, y_a}, 32'h0);
    check("t6_idx_after_rst", {29'b0, idx_a}, 32'h0);
    rst_a = 1'b0;
    #1;
    check("t6_ready_after_rst", {31'b0, sel_ready_a}, 32'h1);
    en_a = 1'b0;
    tick();
    check("a_queue_drained", q_a.size(), 32'h0);
`ifdef DECODER_SEQ_ERR_EN
    check("a_err_clear", {31'b0, err_a}, 32'h0);
`endif

    // Scan on six lines, dwell 2: 0..5 pairs, wrap to 0, then exit on idx 3.
    rst_b  = 1'b0;
    en_b   = 1'b1;
    mode_b = 1'b1;
    for (int i = 0; i < 6; i++) push_b(8'(1 << i), 3'(i), 2);
    for (int i = 0; i < 4; i++) push_b(8'(1 << i), 3'(i), 2);
    tick();
    repeat (18) tick();
    mode_b = 1'b0;
    tick();
    check("t4_idx3_second_cycle", {26'b0, y_b}, 32'h08);
    tick();
    check("t4_scan_exit_y", {26'b0, y_b}, 32'h0);
    check("t4_scan_exit_idx", {29'b0, idx_b}, 32'h0);
    #1;
    check("t4_scan_exit_idle", {31'b0, sel_ready_b}, 32'h1);

    // Enable dropped mid-dwell: line clears on the next edge.
    mode_b = 1'b1;
    push_b(8'h01, 3'd0, 1);
    tick();
    en_b = 1'b0;
    tick();
    check("t4_en_drop_y", {26'b0, y_b}, 32'h0);
    check("t4_en_drop_idx", {29'b0, idx_b}, 32'h0);
    mode_b = 1'b0;
    en_b = 1'b1;
    #1;
    check("t4_en_drop_idle", {31'b0, sel_ready_b}, 32'h1);
`ifdef DECODER_SEQ_ERR_EN
    check("t5_err_before", {31'b0, err_b}, 32'h0);
`endif

    // Out-of-range selects 6 and 7 are consumed and dropped.
    for (int s = 6; s < 8; s++) begin
      sel_b = 3'(s);
      sel_valid_b = 1'b1;
      #1;
      check("t5_ready_oor", {31'b0, sel_ready_b}, 32'h1);
      tick();
      sel_valid_b = 1'b0;
      check("t5_y_stays_zero", {26'b0, y_b}, 32'h0);
      #1;
      check("t5_still_idle", {31'b0, sel_ready_b}, 32'h1);
`ifdef DECODER_SEQ_ERR_EN
      check("t5_err_set", {31'b0, err_b}, 32'h1);
`endif
    end

    // Highest legal line still works afterwards.
    sel_b = 3'd5;
    sel_valid_b = 1'b1;
    push_b(8'h20, 3'd5, 2);
    tick();
    sel_valid_b = 1'b0;
    tick();
    tick();
    check("t5_legal_done", {26'b0, y_b}, 32'h0);
`ifdef DECODER_SEQ_ERR_EN
    check("t5_err_sticky", {31'b0, err_b}, 32'h1);
`endif
    rst_b = 1'b1;
    tick();
    rst_b = 1'b0;
`ifdef DECODER_SEQ_ERR_EN
    check("t5_err_cleared", {31'b0, err_b}, 32'h0);
`endif
    en_b = 1'b0;
    tick();
    tick();
    check("b_queue_drained", q_b.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/decoder_seq.md
Name: decoder_seq

Overview:
- Parametrised registered successor to the 3-to-8 decoder: SEL_W-bit select in, NUM_OUT one-hot outputs.
- Two modes:
  - Direct decode: a valid/ready handshake accepts a select, then the decoded line is held for DWELL cycles.
  - Scan: an internal counter walks the outputs round-robin, dwelling DWELL cycles on each.
- Drives strobe/select lines for downstream peripheral banks.

Parameters:
SEL_W, 3, select width in bits.
NUM_OUT, 8, number of output lines; 2 <= NUM_OUT <= 2**SEL_W; need not be a power of two.
DWELL, 4, cycles each output stays asserted; DWELL >= 1.

Ports:
clk  input  1  clock; all logic on rising edge.
rst  input  1  synchronous reset, active-high.
en  input  1  block enable.
mode  input  1  0 = direct decode, 1 = scan.
sel_valid  input  1  select request valid.
sel  input  SEL_W  requested output index.
sel_ready  output  1  block can accept a select.
y  output  NUM_OUT  registered one-hot (or all-zero) outputs.
y_valid  output  1  equals |y.
idx  output  SEL_W  index of the asserted line; 0 when y == 0.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: state = IDLE, y = 0, y_valid = 0, idx = 0, dwell counter = 0, sel_ready = 0 during the reset cycle.
- sel_ready is combinational: 1 only when state == IDLE && en && !mode && !rst.
- States: IDLE, HOLD, SCAN.
- IDLE:
  - y = 0.
  - Handshake (sel_valid && sel_ready) with sel < NUM_OUT: next edge y = 1<<sel, idx = sel, cnt = DWELL-1, go to HOLD. Latency is 1 cycle from the accepting edge to y.
  - Handshake with sel >= NUM_OUT: the request is consumed and dropped; remain in IDLE; y stays 0.
  - en && mode: next edge go to SCAN, y = 1, idx = 0, cnt = DWELL-1.
- HOLD:
  - sel_ready = 0; new requests stall.
  - cnt > 0: decrement.
  - cnt == 0: next edge y = 0, go to IDLE. The line is asserted for exactly DWELL cycles.
  - mode changes are ignored until IDLE is reached.
- SCAN:
  - cnt > 0: decrement.
  - cnt == 0 && mode: idx = (idx == NUM_OUT-1) ? 0 : idx+1, y = 1<<new idx, cnt = DWELL-1. Wrap is to 0 at NUM_OUT-1, never at 2**SEL_W-1.
  - cnt == 0 && !mode: y = 0, idx = 0, go to IDLE. A scan dwell is never truncated by mode.
- en low in any state: next edge y = 0, idx = 0, go to IDLE. This overrides dwell completion.
- rst asserted mid-HOLD or mid-SCAN: the reset values apply on that edge; no partial dwell resumes.
- Invariant: y is always one-hot or zero; y_valid == |y; idx is consistent with y.
- DWELL == 1: HOLD lasts one cycle. In SCAN, y moves to the next line every cycle.
- Widths: cnt is $clog2(DWELL+1) bits, minimum 1. All index compares are done at SEL_W bits.

Optional Feature:
Macro DECODER_SEQ_ERR_EN.
- Defined: adds output err (1 bit).
  - err is sticky: set on the edge after any accepted handshake with sel >= NUM_OUT.
  - err is cleared only by rst.
  - Reset value 0.
- Undefined: the port is absent; out-of-range requests are silently dropped as described above.

Decomposition:
- Shared package decoder_pkg holds:
  - State enum type dec_state_t (IDLE/HOLD/SCAN).
  - Constants MODE_DIRECT = 1'b0 and MODE_SCAN = 1'b1.
  - Function onehot(idx, NUM_OUT).
- One natural sub-module: dwell_counter. It takes load, load value and enable, and outputs cnt and done (cnt == 0). It is reusable by other strobe generators.

Test Plan:
1. Direct decode, defaults: after rst, en = 1, mode = 0, sel = 5 with sel_valid for 1 cycle -> y = 8'b0010_0000 from the next cycle for exactly 4 cycles, then 0. sel_ready is 0 during those 4 cycles, and idx = 5.
2. Back-to-back requests: sel_valid held with sel = 2, then sel = 6 -> the second request is accepted only on the cycle sel_ready returns to 1. y = 0x04 for 4 cycles, one cycle of 0, then 0x40 for 4 cycles.
3. Scan wrap with NUM_OUT = 6, DWELL = 2: mode = 1 -> idx sequence 0,0,1,1,…,5,5,0,0. y never equals 1<<6 or 1<<7.
4. Scan exit: mode dropped mid-dwell on idx = 3 -> idx 3 completes its 2 cycles, then y = 0 and state is IDLE. en dropped mid-dwell -> y = 0 on the next edge.
5. Out of range with NUM_OUT = 6: sel = 7 handshake -> y stays 0 and state stays IDLE. With DECODER_SEQ_ERR_EN defined, err rises on the next edge and stays 1 until rst.
6. Reset mid-HOLD: rst pulsed during cycle 2 of a sel = 1 hold -> y = 0, idx = 0 on that edge. With rst low and en = 1, sel_ready returns to 1 in the following cycle.
